// File: rtl/entry_cfg_if.sv
// Host request/response and per-entry config bus bundled for the entry config initiator.
// master is the initiator's view; slave is the host plus entry-array view.
interface entry_cfg_if #(
  parameter int ENTRY_NUM = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_wr_rd;
  logic [7:0]              req_entry;
  logic [5:0]              req_addr;
  logic [31:0]             req_wdata;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [31:0]             resp_rdata;
  logic [1:0]              resp_err;
  logic [ENTRY_NUM-1:0]    cfg_cs_n;
  logic                    cfg_wr_rd;
  logic [5:0]              cfg_addr;
  logic [31:0]             cfg_wdata;
  logic [ENTRY_NUM-1:0]    cfg_ack_n;
  logic [32*ENTRY_NUM-1:0] cfg_rdata;

  modport master (
    input  req_valid, req_wr_rd, req_entry, req_addr, req_wdata, resp_ready,
           cfg_ack_n, cfg_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           cfg_cs_n, cfg_wr_rd, cfg_addr, cfg_wdata
  );

  modport slave (
    output req_valid, req_wr_rd, req_entry, req_addr, req_wdata, resp_ready,
           cfg_ack_n, cfg_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           cfg_cs_n, cfg_wr_rd, cfg_addr, cfg_wdata
  );
endinterface

// File: rtl/entry_cfg_master.sv
// Config bus initiator: takes one host request, runs a 4-phase cs_n/ack_n handshake
// with the addressed entry block and returns read data or an error status.
module entry_cfg_master #(
  parameter int ENTRY_NUM   = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  entry_cfg_if.master bus
);
  localparam int SEL_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ENTRY = 2'd1;
  localparam logic [1:0] ERR_ACK   = 2'd2;
  localparam logic [1:0] ERR_REL   = 2'd3;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    REQ_S  = 2'd1,
    REL_S  = 2'd2,
    RESP_S = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [SEL_W-1:0]     sel, sel_nxt;
  logic [TMR_W-1:0]     timer, timer_nxt;
  logic [ENTRY_NUM-1:0] cs_n, cs_n_nxt;
  logic                 wr_rd, wr_rd_nxt;
  logic [5:0]           addr, addr_nxt;
  logic [31:0]          wdata, wdata_nxt;
  logic                 req_ready, req_ready_nxt;
  logic                 resp_valid, resp_valid_nxt;
  logic [31:0]          resp_rdata, resp_rdata_nxt;
  logic [1:0]           resp_err, resp_err_nxt;

  logic                 ack_sel;
  logic [31:0]          rdata_sel;
  logic                 entry_ok;

  // Only the latched entry's lane is ever looked at.
  always_comb begin
    ack_sel   = 1'b1;
    rdata_sel = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (sel == SEL_W'(i)) begin
        ack_sel   = bus.cfg_ack_n[i];
        rdata_sel = bus.cfg_rdata[32*i +: 32];
      end
    end
  end

  assign entry_ok = ({1'b0, bus.req_entry} < 9'(ENTRY_NUM));

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    timer_nxt      = timer;
    cs_n_nxt       = cs_n;
    wr_rd_nxt      = wr_rd;
    addr_nxt       = addr;
    wdata_nxt      = wdata;
    resp_valid_nxt = resp_valid;
    resp_rdata_nxt = resp_rdata;
    resp_err_nxt   = resp_err;

    case (state)
      IDLE_S: begin
        if (bus.req_valid && req_ready) begin
          wr_rd_nxt = bus.req_wr_rd;
          addr_nxt  = bus.req_addr;
          wdata_nxt = bus.req_wdata;
          sel_nxt   = bus.req_entry[SEL_W-1:0];
          if (!entry_ok) begin
            resp_err_nxt   = ERR_ENTRY;
            resp_rdata_nxt = '0;
            resp_valid_nxt = 1'b1;
            state_nxt      = RESP_S;
          end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
              cs_n_nxt[i] = (bus.req_entry != 8'(i));
            end
            resp_err_nxt = ERR_OK;
            timer_nxt    = '0;
            state_nxt    = REQ_S;
          end
        end
      end

      REQ_S: begin
        timer_nxt = timer + 1'b1;
        // A late ack that lands on the expiry cycle still counts as success.
        if (!ack_sel) begin
          resp_rdata_nxt = wr_rd ? rdata_sel : 32'd0;
          cs_n_nxt       = '1;
          timer_nxt      = '0;
          state_nxt      = REL_S;
        end else if (timer == TMR_LAST) begin
          resp_err_nxt   = ERR_ACK;
          resp_rdata_nxt = '0;
          cs_n_nxt       = '1;
          timer_nxt      = '0;
          state_nxt      = REL_S;
        end
      end

      REL_S: begin
        timer_nxt = timer + 1'b1;
        if (ack_sel) begin
          resp_valid_nxt = 1'b1;
          timer_nxt      = '0;
          state_nxt      = RESP_S;
        end else if (timer == TMR_LAST) begin
          if (resp_err != ERR_ACK) begin
            resp_err_nxt   = ERR_REL;
            resp_rdata_nxt = '0;
          end
          resp_valid_nxt = 1'b1;
          timer_nxt      = '0;
          state_nxt      = RESP_S;
        end
      end

      RESP_S: begin
        if (bus.resp_ready) begin
          resp_valid_nxt = 1'b0;
          resp_rdata_nxt = '0;
          resp_err_nxt   = ERR_OK;
          state_nxt      = IDLE_S;
        end
      end

      default: state_nxt = IDLE_S;
    endcase

    req_ready_nxt = (state_nxt == IDLE_S);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE_S;
      sel        <= '0;
      timer      <= '0;
      cs_n       <= '1;
      wr_rd      <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      timer      <= timer_nxt;
      cs_n       <= cs_n_nxt;
      wr_rd      <= wr_rd_nxt;
      addr       <= addr_nxt;
      wdata      <= wdata_nxt;
      req_ready  <= req_ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
      resp_err   <= resp_err_nxt;
    end
  end

  assign bus.cfg_cs_n   = cs_n;
  assign bus.cfg_wr_rd  = wr_rd;
  assign bus.cfg_addr   = addr;
  assign bus.cfg_wdata  = wdata;
  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;
  assign bus.resp_err   = resp_err;
endmodule

// File: tb/tb_entry_cfg_master.sv
// Bench for entry_cfg_master: directed handshake cases plus randomized requests
// against a transaction-level model of latency, error code and register contents.
module tb_entry_cfg_master;
  localparam int N     = 16;
  localparam int T     = 8;
  localparam int NOISE = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  entry_cfg_if #(.ENTRY_NUM(N)) bus ();

  entry_cfg_master #(.ENTRY_NUM(N), .TIMEOUT_CYC(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Entry responder configuration: ack delay in sampled cs_n-low edges, never-ack, hold ack low.
  int        dly   [N];
  bit        noack [N];
  bit        hold  [N];
  bit        noise_en;
  int        cnt   [N];
  bit [31:0] mem     [N][64];
  bit [31:0] ref_mem [N][64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cfg_ack_n <= '1;
      bus.cfg_rdata <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i == NOISE && noise_en) begin
          bus.cfg_ack_n[i]         <= 1'($urandom_range(0, 1));
          bus.cfg_rdata[32*i +: 32] <= $urandom;
          cnt[i]                   <= 0;
        end else if (!bus.cfg_cs_n[i]) begin
          cnt[i] <= cnt[i] + 1;
          if (!noack[i] && (cnt[i] + 1 == dly[i])) begin
            bus.cfg_ack_n[i] <= 1'b0;
            if (bus.cfg_wr_rd) begin
              bus.cfg_rdata[32*i +: 32] <= mem[i][bus.cfg_addr];
            end else begin
              mem[i][bus.cfg_addr]      <= bus.cfg_wdata;
              bus.cfg_rdata[32*i +: 32] <= $urandom;
            end
          end
        end else begin
          cnt[i] <= 0;
          if (!hold[i]) bus.cfg_ack_n[i] <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  // rd: 1 read / 0 write; d: responder ack delay; na: never ack; hd: hold ack low; rwait: resp_ready stall
  task automatic do_txn(input bit rd, input int entry, input bit [5:0] addr, input bit [31:0] wdata,
                        input int d, input bit na, input bit hd, input int rwait);
    int          lat_exp, cs_exp, j, cs_low;
    bit [1:0]    err_exp;
    bit [31:0]   rd_exp;
    bit          bad_cs, unstable, resp_moved;
    logic [N-1:0] others;

    rd_exp = 32'd0;
    if (entry >= N) begin
      err_exp = 2'd1; lat_exp = 0; cs_exp = 0;
    end else if (na || d < 1 || d > T - 1) begin
      err_exp = 2'd2; lat_exp = T + 1; cs_exp = T;
    end else begin
      cs_exp = d + 1;
      if (rd) rd_exp = ref_mem[entry][addr];
      else    ref_mem[entry][addr] = wdata;
      if (hd) begin
        err_exp = 2'd3; lat_exp = d + 1 + T; rd_exp = 32'd0;
      end else begin
        err_exp = 2'd0; lat_exp = d + 3;
      end
    end

    if (entry < N) begin
      dly[entry]   = d;
      noack[entry] = na;
      hold[entry]  = hd;
    end
    noise_en = (entry != NOISE);

    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_wr_rd = rd;
    bus.req_entry = 8'(entry);
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wr_rd = 1'($urandom_range(0, 1));
    bus.req_addr  = 6'($urandom);
    bus.req_wdata = $urandom;

    others = '1;
    if (entry < N) others[entry] = 1'b0;
    j = 0; cs_low = 0; bad_cs = 0; unstable = 0;
    while (j <= 4 * T + 20) begin
      if (entry < N && !bus.cfg_cs_n[entry]) cs_low++;
      if ((bus.cfg_cs_n & others) != others) bad_cs = 1'b1;
      if (bus.cfg_addr != addr || bus.cfg_wdata != wdata || bus.cfg_wr_rd != rd) unstable = 1'b1;
      if (bus.resp_valid) break;
      @(negedge clk);
      j++;
    end

    check("latency",    32'(j),              32'(lat_exp));
    check("cs_low_cyc", 32'(cs_low),         32'(cs_exp));
    check("other_cs",   32'(bad_cs),         32'd0);
    check("bcast_hold", 32'(unstable),       32'd0);
    check("resp_err",   32'(bus.resp_err),   32'(err_exp));
    check("resp_rdata", bus.resp_rdata,      rd_exp);
    check("busy_ready", 32'(bus.req_ready),  32'd0);

    resp_moved = 1'b0;
    for (int i = 0; i < rwait; i++) begin
      @(negedge clk);
      if (!bus.resp_valid || bus.resp_err != err_exp || bus.resp_rdata != rd_exp || bus.req_ready)
        resp_moved = 1'b1;
    end
    if (rwait > 0) check("resp_stall", 32'(resp_moved), 32'd0);

    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("done_valid", 32'(bus.resp_valid), 32'd0);
    check("done_err",   32'(bus.resp_err),   32'd0);
    check("done_rdata", bus.resp_rdata,      32'd0);
    check("done_ready", 32'(bus.req_ready),  32'd1);

    if (hd && entry < N) begin
      hold[entry] = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_wr_rd  = 1'b0;
    bus.req_entry  = 8'd0;
    bus.req_addr   = 6'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b0;
    noise_en       = 1'b1;
    for (int i = 0; i < N; i++) begin
      dly[i] = 3; noack[i] = 1'b0; hold[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    check("rst_cs_n",   32'(bus.cfg_cs_n),   32'h0000_FFFF);
    check("rst_ready",  32'(bus.req_ready),  32'd0);
    check("rst_valid",  32'(bus.resp_valid), 32'd0);
    check("rst_rdata",  bus.resp_rdata,      32'd0);
    check("rst_err",    32'(bus.resp_err),   32'd0);
    check("rst_addr",   32'(bus.cfg_addr),   32'd0);
    check("rst_wdata",  bus.cfg_wdata,       32'd0);
    check("rst_wr_rd",  32'(bus.cfg_wr_rd),  32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_pre",  32'(bus.req_ready),  32'd0);
    @(negedge clk);
    check("ready_rise", 32'(bus.req_ready),  32'd1);

    // Write then read back entry 3, nominal 3-edge responder
    do_txn(1'b0, 3, 6'h20, 32'h0000_005A, 3, 1'b0, 1'b0, 0);
    do_txn(1'b1, 3, 6'h20, 32'h0,         3, 1'b0, 1'b0, 0);
    // Out-of-range entries
    do_txn(1'b0, 200, 6'h01, 32'h1234_5678, 3, 1'b0, 1'b0, 0);
    do_txn(1'b1, 16,  6'h02, 32'h0,         3, 1'b0, 1'b0, 1);
    // Ack timeout on entry 5
    do_txn(1'b1, 5, 6'h10, 32'h0, 3, 1'b1, 1'b0, 0);
    // Host stalls the response for 5 cycles
    do_txn(1'b0, 4, 6'h21, 32'hCAFE_F00D, 2, 1'b0, 1'b0, 5);
    do_txn(1'b1, 4, 6'h21, 32'h0,         1, 1'b0, 1'b0, 5);
    // Ack lands on the timeout cycle: ack wins
    do_txn(1'b0, 9, 6'h00, 32'hA5A5_0001, T - 1, 1'b0, 1'b0, 0);
    do_txn(1'b1, 9, 6'h00, 32'h0,         T - 1, 1'b0, 1'b0, 0);
    // Release timeout: ack stays low after cs_n rises
    do_txn(1'b1, 9, 6'h00, 32'h0, 2, 1'b0, 1'b1, 0);
    // Highest lane (normally noisy) as a real target
    do_txn(1'b0, 15, 6'h11, 32'h0F0F_1234, 3, 1'b0, 1'b0, 0);
    do_txn(1'b1, 15, 6'h11, 32'h0,         4, 1'b0, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      int  e, d;
      bit  na, hd;
      e  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 255)) : int'($urandom_range(0, 15));
      na = ($urandom_range(0, 5) == 0);
      d  = int'($urandom_range(1, T - 1));
      hd = !na && ($urandom_range(0, 7) == 0);
      do_txn(1'($urandom_range(0, 1)), e, 6'($urandom_range(0, 33)), $urandom, d, na, hd,
             int'($urandom_range(0, 4)));
    end

    // Reset in the middle of REQ_S drops the request
    noack[7] = 1'b1;
    noise_en = 1'b1;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_wr_rd = 1'b1;
    bus.req_entry = 8'd7;
    bus.req_addr  = 6'h05;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_cs", 32'(bus.cfg_cs_n), 32'h0000_FF7F);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cs_n",  32'(bus.cfg_cs_n),   32'h0000_FFFF);
    check("arst_valid", 32'(bus.resp_valid), 32'd0);
    check("arst_ready", 32'(bus.req_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    noack[7] = 1'b0;
    do_txn(1'b0, 7, 6'h05, 32'h7777_0005, 3, 1'b0, 1'b0, 0);
    do_txn(1'b1, 7, 6'h05, 32'h0,         3, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
